// File: rtl/sync_debounce_bus.sv
// sync_debounce_bus: per-channel synchroniser followed by a stability filter for slow async inputs.
// Define SYNC_DEBOUNCE_EDGE_EN to build the registered rise/fall/changed strobes; otherwise they are tied low.
module sync_debounce_bus #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_WIDTH     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_clear,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_done;
  logic [WIDTH-1:0] w_out;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_WIDTH-1:0]   r_cnt;
      logic                   r_out;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], d_in[gi]};
      end

      assign w_s[gi]    = r_sync[SYNC_STAGES-1];
      // Qualification completes on the FILTER_CYCLES-th consecutive disagreeing sample.
      assign w_done[gi] = (w_s[gi] != r_out) && (r_cnt == CNT_LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
          r_out <= 1'b0;
        end else if (sync_clear) begin
          r_cnt <= '0;
          r_out <= 1'b0;
        end else if (w_s[gi] == r_out) begin
          r_cnt <= '0;
        end else if (w_done[gi]) begin
          r_out <= w_s[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_out[gi] = r_out;
    end
  endgenerate

  assign d_out = w_out;

`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] w_rise_next;
  logic [WIDTH-1:0] w_fall_next;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  assign w_rise_next = w_done & w_s;
  assign w_fall_next = w_done & ~w_s;

  // Strobes register on the same edge as d_out so they line up with the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else if (sync_clear) begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_rise    <= w_rise_next;
      r_fall    <= w_fall_next;
      r_changed <= |(w_rise_next | w_fall_next);
    end
  end

  assign rise    = r_rise;
  assign fall    = r_fall;
  assign changed = r_changed;
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_sync_debounce_bus.sv
// Directed bench for sync_debounce_bus (WIDTH=8, SYNC_STAGES=2, FILTER_CYCLES=3).
// Strobe expectations follow SYNC_DEBOUNCE_EDGE_EN; with it undefined they must stay 0.
module tb_sync_debounce_bus;

`ifdef SYNC_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sync_clear = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       changed;

  int n_checks = 0;
  int n_fail   = 0;

  sync_debounce_bus #(
    .WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(3), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .sync_clear(sync_clear), .d_in(d_in),
    .d_out(d_out), .rise(rise), .fall(fall), .changed(changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [7:0] din, input logic [7:0] dout,
                     input logic [7:0] r, input logic [7:0] f, input logic c);
    vec_t v;
    v.din = din; v.dout = dout; v.rise = r; v.fall = f; v.chg = c;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare all four outputs; strobe expectations collapse to 0 in the no-edge build.
  task automatic check_all(input string tag, input logic [7:0] e_out, input logic [7:0] e_rise,
                           input logic [7:0] e_fall, input logic e_chg);
    check({tag, " d_out"}, d_out, e_out);
    check({tag, " rise"}, rise, EDGE_EN ? e_rise : 8'h00);
    check({tag, " fall"}, fall, EDGE_EN ? e_fall : 8'h00);
    check({tag, " changed"}, {7'd0, changed}, {7'd0, EDGE_EN ? e_chg : 1'b0});
    $display("%s: d_in=%h d_out=%h rise=%h fall=%h changed=%b", tag, d_in, d_out, rise, fall, changed);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Step, return-to-zero, 2-clock glitch, 3-clock pulse, then all-channel transitions.
    add(4, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1);
    add(2, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
    add(4, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0);
    add(1, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    add(2, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0);
    add(4, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    add(3, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1, 8'h00, 8'h08, 8'h08, 8'h00, 1'b1);
    add(2, 8'h00, 8'h08, 8'h00, 8'h00, 1'b0);
    add(1, 8'h00, 8'h00, 8'h00, 8'h08, 1'b1);
    add(1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    add(4, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1, 8'hA5, 8'hA5, 8'hA5, 8'h00, 1'b1);
    add(1, 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0);
    add(4, 8'h5A, 8'hA5, 8'h00, 8'h00, 1'b0);
    add(1, 8'h5A, 8'h5A, 8'h5A, 8'hA5, 1'b1);
    add(1, 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b0);

    #1;
    check_all("reset state", 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      d_in = vecs[k].din;
      tick();
      check_all($sformatf("row %0d", k), vecs[k].dout, vecs[k].rise, vecs[k].fall, vecs[k].chg);
    end

    // Reset mid-qualification: channels A5 have a partial count toward 1.
    d_in = 8'hFF;
    repeat (3) tick();
    check_all("pre-reset", 8'h5A, 8'h00, 8'h00, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_all("async reset", 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      if (e < 4) check_all($sformatf("post-reset edge %0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
      else       check_all("post-reset edge 4", 8'hFF, 8'hFF, 8'h00, 1'b1);
    end

    // Bring d_out to 0F, then collide sync_clear with channel 5 qualifying.
    d_in = 8'h0F;
    for (int e = 0; e < 5; e++) begin
      tick();
      if (e < 4) check_all($sformatf("to-0F edge %0d", e), 8'hFF, 8'h00, 8'h00, 1'b0);
      else       check_all("to-0F edge 4", 8'h0F, 8'h00, 8'hF0, 1'b1);
    end
    d_in = 8'h2F;
    for (int e = 0; e < 4; e++) begin
      tick();
      check_all($sformatf("ch5 qual edge %0d", e), 8'h0F, 8'h00, 8'h00, 1'b0);
    end
    sync_clear = 1'b1;
    tick();
    check_all("clear priority", 8'h00, 8'h00, 8'h00, 1'b0);
    sync_clear = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      if (e < 2)       check_all($sformatf("requal edge %0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
      else if (e == 2) check_all("requal edge 2", 8'h2F, 8'h2F, 8'h00, 1'b1);
      else             check_all("requal edge 3", 8'h2F, 8'h00, 8'h00, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
